// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment display scheduler:
// scheduler state encoding, hex-to-segment table and time conversion.
package sev_seg_pkg;

  // Scheduler states: nobody owns the display, an owner is shown, or the
  // blank gap between two owners.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Active-high segments {g,f,e,d,c,b,a}, indexed by nibble value.
  // 'b' and 'd' are drawn lowercase so they are not confused with 8 and 0.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  // Milliseconds to clock ticks; never returns less than one tick so the
  // counters always have a valid reload value.
  function automatic int unsigned ms_to_ticks(input int unsigned clk_freq,
                                              input int unsigned ms);
    longint unsigned ticks;
    ticks = (longint'(clk_freq) * longint'(ms)) / 1000;
    if (ticks < 1) ticks = 1;
    return int'(ticks);
  endfunction

endpackage

// File: rtl/hex_to_sev_seg.sv
// Combinational hex nibble to seven-segment decoder.
module hex_to_sev_seg
  import sev_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the table holds the glyph for every nibble.
  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sev_seg_display_scheduler.sv
// Time-shares one 4-digit seven-segment display between NUM_REQ requesters.
// Round-robin grant, fixed dwell per owner, short blank gap between owners.
// All outputs are registered.
module sev_seg_display_scheduler
  import sev_seg_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CLK_FREQ = 1_000,
  parameter int DWELL_MS = 1000,
  parameter int BLANK_MS = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  value,
  input  logic [4*NUM_REQ-1:0]   dots_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [6:0]             digit_0,
  output logic [6:0]             digit_1,
  output logic [6:0]             digit_2,
  output logic [6:0]             digit_3,
  output logic [3:0]             dots,
  output logic                   display_en
);

  localparam int unsigned DWELL_TICKS = ms_to_ticks(CLK_FREQ, DWELL_MS);
  localparam int unsigned BLANK_TICKS = ms_to_ticks(CLK_FREQ, BLANK_MS);
  localparam int unsigned MAX_TICKS   = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CNT_W = $clog2(MAX_TICKS + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_TICKS - 1);
  localparam logic [PTR_W-1:0] PTR_INIT   = PTR_W'(NUM_REQ - 1);

  // Scheduler state
  sched_state_t      state_reg, state_next;
  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  dwell_reg, dwell_next;
  logic [CNT_W-1:0]  blank_reg, blank_next;

  // Output registers
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [6:0]         digit_reg  [4];
  logic [6:0]         digit_next [4];
  logic [3:0]         dots_reg, dots_next;
  logic               display_en_reg, display_en_next;

  // Per-requester views of the packed value/dots buses
  logic [15:0] req_value [NUM_REQ];
  logic [3:0]  req_dots  [NUM_REQ];
  logic [15:0] owner_value;
  logic [6:0]  seg_live  [4];

  // Arbiter result
  logic             arb_found;
  logic [PTR_W-1:0] arb_idx;
  logic             owner_req;
  logic             other_req;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_value[gi] = value[16*gi +: 16];
      assign req_dots[gi]  = dots_in[4*gi +: 4];
    end
  endgenerate

  // The owner is always the requester rr_ptr points at while in SHOW.
  assign owner_value = req_value[rr_ptr_reg];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_hex
      hex_to_sev_seg u_hex (
        .nibble (owner_value[4*gi +: 4]),
        .seg    (seg_live[gi])
      );
    end
  endgenerate

  assign owner_req = |(req & grant_reg);
  assign other_req = |(req & ~grant_reg);

  // Round-robin search starting just after the last winner, wrapping.
  always_comb begin
    int cand;
    logic [PTR_W-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_reg) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Next-state logic; with en low every piece of scheduler state holds.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    dwell_next  = dwell_reg;
    blank_next  = blank_reg;
    grant_next  = grant_reg;
    if (en) begin
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            state_next  = SHOW;
            rr_ptr_next = arb_idx;
            grant_next  = NUM_REQ'(1) << arb_idx;
            dwell_next  = DWELL_LOAD;
          end
        end
        SHOW: begin
          // A drop wins over a simultaneous dwell expiry.
          if (!owner_req) begin
            state_next = GAP;
            grant_next = '0;
            blank_next = BLANK_LOAD;
          end else if (dwell_reg == '0) begin
            if (other_req) begin
              state_next = GAP;
              grant_next = '0;
              blank_next = BLANK_LOAD;
            end else begin
              // Sole requester keeps the display without a blank.
              dwell_next = DWELL_LOAD;
            end
          end else begin
            dwell_next = dwell_reg - CNT_W'(1);
          end
        end
        GAP: begin
          if (blank_reg == '0) begin
            if (arb_found) begin
              state_next  = SHOW;
              rr_ptr_next = arb_idx;
              grant_next  = NUM_REQ'(1) << arb_idx;
              dwell_next  = DWELL_LOAD;
            end else begin
              state_next = IDLE;
            end
          end else begin
            blank_next = blank_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          grant_next = '0;
        end
      endcase
    end
  end

  // Display data follows the owner live while it stays in SHOW, else blank.
  always_comb begin
    display_en_next = en && (state_next == SHOW);
    dots_next       = dots_reg;
    for (int d = 0; d < 4; d++) digit_next[d] = digit_reg[d];
    if (en) begin
      if (state_reg == SHOW && state_next == SHOW) begin
        for (int d = 0; d < 4; d++) digit_next[d] = seg_live[d];
        dots_next = req_dots[rr_ptr_reg];
      end else begin
        for (int d = 0; d < 4; d++) digit_next[d] = '0;
        dots_next = '0;
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= PTR_INIT;
      dwell_reg  <= '0;
      blank_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      dwell_reg  <= dwell_next;
      blank_reg  <= blank_next;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_reg      <= '0;
      dots_reg       <= '0;
      display_en_reg <= 1'b0;
      for (int d = 0; d < 4; d++) digit_reg[d] <= '0;
    end else begin
      grant_reg      <= grant_next;
      dots_reg       <= dots_next;
      display_en_reg <= display_en_next;
      for (int d = 0; d < 4; d++) digit_reg[d] <= digit_next[d];
    end
  end

  assign grant      = grant_reg;
  assign digit_0    = digit_reg[0];
  assign digit_1    = digit_reg[1];
  assign digit_2    = digit_reg[2];
  assign digit_3    = digit_reg[3];
  assign dots       = dots_reg;
  assign display_en = display_en_reg;

endmodule

// File: tb/tb_sev_seg_display_scheduler.sv
// Directed bench for sev_seg_display_scheduler with DWELL_TICKS=10, BLANK_TICKS=2.
module tb_sev_seg_display_scheduler;

  localparam int NUM_REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en  = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [16*NUM_REQ-1:0] value = '0;
  logic [4*NUM_REQ-1:0]  dots_in = '0;
  logic [NUM_REQ-1:0]    grant;
  logic [6:0]            digit_0, digit_1, digit_2, digit_3;
  logic [3:0]            dots;
  logic                  display_en;

  int vec_cnt = 0;
  int err_cnt = 0;

  sev_seg_display_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .CLK_FREQ (1000),
    .DWELL_MS (10),
    .BLANK_MS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .value      (value),
    .dots_in    (dots_in),
    .grant      (grant),
    .digit_0    (digit_0),
    .digit_1    (digit_1),
    .digit_2    (digit_2),
    .digit_3    (digit_3),
    .dots       (dots),
    .display_en (display_en)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] all_out;
    rst = 1'b1; en = 1'b1; req = '0; value = '0; dots_in = '0;
    tick(3);
    all_out = {grant, digit_0, digit_1, digit_2, digit_3, dots, display_en};
    vec_cnt++;
    if (all_out !== 37'd0) begin
      $display("FAIL reset_values: got %h, want 0", all_out); err_cnt++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      vec_cnt++;
      if ({grant, display_en} !== 5'b0000_0) begin
        $display("FAIL idle_no_req: cycle %0d grant=%b en=%b, want 0000/0", i, grant, display_en); err_cnt++;
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    req = 4'b0001;
    value[15:0] = 16'h1234;
    dots_in[3:0] = 4'b1010;
    tick(1);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0001_1) begin
      $display("FAIL single_grant: grant=%b en=%b, want 0001/1", grant, display_en); err_cnt++;
    end
    tick(1);
    vec_cnt++;
    if ({digit_3, digit_2, digit_1, digit_0, dots} !== {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 4'b1010}) begin
      $display("FAIL single_digits: d3..d0=%b %b %b %b dots=%b, want 0000110 1011011 1001111 1100110 1010",
               digit_3, digit_2, digit_1, digit_0, dots); err_cnt++;
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      vec_cnt++;
      if ({grant, display_en, digit_0} !== {4'b0001, 1'b1, 7'b1100110}) begin
        $display("FAIL single_hold: cycle %0d grant=%b en=%b d0=%b, want 0001/1/1100110", i, grant, display_en, digit_0);
        err_cnt++;
      end
    end
    value[15:0] = 16'hABCD;
    tick(1);
    vec_cnt++;
    if ({digit_3, digit_2, digit_1, digit_0} !== {7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110}) begin
      $display("FAIL live_update: d3..d0=%b %b %b %b, want 1110111 1111100 0111001 1011110",
               digit_3, digit_2, digit_1, digit_0); err_cnt++;
    end
    req = 4'b0000;
    tick(1);
    vec_cnt++;
    if ({grant, display_en, digit_0, dots} !== 16'd0) begin
      $display("FAIL drop_blank: grant=%b en=%b d0=%b dots=%b, want all 0", grant, display_en, digit_0, dots); err_cnt++;
    end
    tick(2);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vec_cnt++;
      if ({grant, display_en} !== 5'b0000_0) begin
        $display("FAIL back_to_idle: cycle %0d grant=%b en=%b, want 0000/0", i, grant, display_en); err_cnt++;
      end
    end
    $display("test_single done");
  endtask

  task automatic test_alternate();
    logic [3:0] exp_grant;
    int slot, phase;
    do_reset();
    req = 4'b0101;
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      slot  = (k - 1) / 12;
      phase = (k - 1) % 12;
      exp_grant = (phase < 10) ? ((slot % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
      vec_cnt++;
      if ({grant, display_en} !== {exp_grant, (phase < 10)}) begin
        $display("FAIL alternate: cycle %0d grant=%b en=%b, want %b/%0d", k, grant, display_en, exp_grant, (phase < 10));
        err_cnt++;
      end
    end
    $display("test_alternate done");
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0011;
    tick(3);
    vec_cnt++;
    if (grant !== 4'b0001) begin
      $display("FAIL drop_pre: grant=%b, want 0001", grant); err_cnt++;
    end
    req = 4'b0010;
    tick(1);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0000_0) begin
      $display("FAIL drop_gap: grant=%b en=%b, want 0000/0", grant, display_en); err_cnt++;
    end
    tick(1);
    vec_cnt++;
    if (grant !== 4'b0000) begin
      $display("FAIL drop_gap2: grant=%b, want 0000", grant); err_cnt++;
    end
    tick(1);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0010_1) begin
      $display("FAIL drop_next: grant=%b en=%b, want 0010/1", grant, display_en); err_cnt++;
    end
    req = 4'b0000;
    tick(3);
    tick(3);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0000_0) begin
      $display("FAIL drop_idle: grant=%b en=%b, want 0000/0", grant, display_en); err_cnt++;
    end
    req = 4'b0001;
    tick(1);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0001_1) begin
      $display("FAIL idle_regrant: grant=%b en=%b, want 0001/1", grant, display_en); err_cnt++;
    end
    $display("test_drop done");
  endtask

  task automatic test_en_freeze();
    do_reset();
    req = 4'b0011;
    tick(4);
    vec_cnt++;
    if (grant !== 4'b0001) begin
      $display("FAIL freeze_pre: grant=%b, want 0001", grant); err_cnt++;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      vec_cnt++;
      if ({grant, display_en} !== 5'b0001_0) begin
        $display("FAIL freeze_hold: cycle %0d grant=%b en=%b, want 0001/0", i, grant, display_en); err_cnt++;
      end
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      vec_cnt++;
      if ({grant, display_en} !== 5'b0001_1) begin
        $display("FAIL freeze_resume: cycle %0d grant=%b en=%b, want 0001/1", i, grant, display_en); err_cnt++;
      end
    end
    tick(1);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0000_0) begin
      $display("FAIL freeze_gap: grant=%b en=%b, want 0000/0", grant, display_en); err_cnt++;
    end
    tick(2);
    vec_cnt++;
    if (grant !== 4'b0010) begin
      $display("FAIL freeze_next: grant=%b, want 0010", grant); err_cnt++;
    end
    $display("test_en_freeze done");
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_grant;
    do_reset();
    req = 4'b1111;
    value = 64'h4321_8765_CBA9_1234;
    dots_in = 16'hFFFF;
    tick(3);
    vec_cnt++;
    if ({grant, digit_0} !== {4'b0001, 7'b1100110}) begin
      $display("FAIL mid_pre: grant=%b d0=%b, want 0001/1100110", grant, digit_0); err_cnt++;
    end
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({grant, digit_0, digit_1, digit_2, digit_3, dots, display_en} !== 37'd0) begin
      $display("FAIL async_rst_show: grant=%b d0=%b dots=%b en=%b, want all 0", grant, digit_0, dots, display_en);
      err_cnt++;
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    vec_cnt++;
    if (grant !== 4'b0001) begin
      $display("FAIL mid_restart: grant=%b, want 0001", grant); err_cnt++;
    end
    tick(10);
    vec_cnt++;
    if ({grant, display_en} !== 5'b0000_0) begin
      $display("FAIL mid_gap: grant=%b en=%b, want 0000/0", grant, display_en); err_cnt++;
    end
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({grant, digit_0, dots, display_en} !== 16'd0) begin
      $display("FAIL async_rst_gap: grant=%b d0=%b dots=%b en=%b, want all 0", grant, digit_0, dots, display_en);
      err_cnt++;
    end
    tick(1);
    rst = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      tick(1);
      if ((k - 1) % 12 == 0) begin
        exp_grant = 4'b0001 << (((k - 1) / 12) % 4);
        vec_cnt++;
        if (grant !== exp_grant) begin
          $display("FAIL rr_order: cycle %0d grant=%b, want %b", k, grant, exp_grant); err_cnt++;
        end
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_en_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
